// File: rtl/lcd_refresh_driver.sv
// lcd_refresh_driver
// Reader side of the 32-byte LCD message buffer. After the power-on wait and
// the HD44780 init commands it endlessly rewrites both 16-character lines:
// set-DDRAM-address command, then 16 characters fetched from the buffer.
// Every transfer (command or character) goes through the same
// SETUP -> PULSE -> HOLD sequence; characters get one extra FETCH cycle in
// front so the buffer's combinational read data can settle on raddr.

module lcd_refresh_driver #(
    parameter int PWR_WAIT_CYC = 750000,
    parameter int SETUP_CYC    = 2,
    parameter int EN_PULSE_CYC = 25,
    parameter int CMD_WAIT_CYC = 2500,
    parameter int CLR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [4:0] raddr,
    input  logic [7:0] din,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       frame_done
);

    // A zero-length phase makes no sense on the bus, so 0 behaves as 1.
    localparam int PWR_N   = (PWR_WAIT_CYC < 1) ? 1 : PWR_WAIT_CYC;
    localparam int SETUP_N = (SETUP_CYC    < 1) ? 1 : SETUP_CYC;
    localparam int PULSE_N = (EN_PULSE_CYC < 1) ? 1 : EN_PULSE_CYC;
    localparam int CMD_N   = (CMD_WAIT_CYC < 1) ? 1 : CMD_WAIT_CYC;
    localparam int CLR_N   = (CLR_WAIT_CYC < 1) ? 1 : CLR_WAIT_CYC;

    // One shared counter serves every timed phase, so size it for the longest.
    localparam int MAX_A = (PWR_N   > SETUP_N) ? PWR_N   : SETUP_N;
    localparam int MAX_B = (PULSE_N > CMD_N)   ? PULSE_N : CMD_N;
    localparam int MAX_C = (MAX_A   > MAX_B)   ? MAX_A   : MAX_B;
    localparam int MAX_N = (MAX_C   > CLR_N)   ? MAX_C   : CLR_N;
    localparam int CW    = $clog2(MAX_N + 1);

    localparam logic [CW-1:0] PWR_LAST   = CW'(PWR_N - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_N - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_N - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_N - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_N - 1);

    // HD44780 command bytes used by this driver
    localparam logic [7:0] CMD_FUNC_SET  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY     = 8'h06;  // auto-increment, no shift
    localparam logic [7:0] CMD_CLEAR     = 8'h01;  // clear display (slow command)
    localparam logic [7:0] CMD_LINE1     = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] CMD_LINE2     = 8'hC0;  // DDRAM address 0x40

    typedef enum logic [2:0] {
        TOP_PWR_WAIT,
        TOP_INIT,
        TOP_LINE1_ADDR,
        TOP_LINE1_CHARS,
        TOP_LINE2_ADDR,
        TOP_LINE2_CHARS
    } top_t;

    typedef enum logic [1:0] {
        PH_FETCH,
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_t;

    top_t            top_q,       top_d;
    phase_t          phase_q,     phase_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [1:0]      init_idx_q,  init_idx_d;
    logic [4:0]      raddr_q,     raddr_d;
    logic [7:0]      data_q,      data_d;
    logic            rs_q,        rs_d;
    logic            on_q,        on_d;
    logic            frame_done_q, frame_done_d;

    logic [CW-1:0]   hold_last;
    logic            hold_done;

    // Init command ROM, indexed by position in the init sequence.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_ENTRY;
            default: cmd = CMD_CLEAR;
        endcase
        return cmd;
    endfunction

    // Buffer byte to display character: small values become digits, anything
    // outside printable ASCII becomes a blank so the panel never shows CGRAM
    // glyphs or the controller's undefined upper-half font.
    function automatic logic [7:0] map_char(input logic [7:0] b);
        logic [7:0] c;
        if (b <= 8'h09) begin
            c = b + 8'h30;
        end else if ((b < 8'h20) || (b >= 8'h7F)) begin
            c = 8'h20;
        end else begin
            c = b;
        end
        return c;
    endfunction

    // The clear command needs the long wait; rs/data are still the last
    // transfer's during HOLD, so they tell us which wait applies.
    always_comb begin
        hold_last = CMD_LAST;
        if (!rs_q && (data_q == CMD_CLEAR)) begin
            hold_last = CLR_LAST;
        end
        hold_done = (phase_q == PH_HOLD) && (cnt_q == hold_last);
    end

    // State register: all flops, asynchronously cleared to the power-on state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q        <= TOP_PWR_WAIT;
            phase_q      <= PH_SETUP;
            cnt_q        <= '0;
            init_idx_q   <= 2'd0;
            raddr_q      <= 5'd0;
            data_q       <= 8'h00;
            rs_q         <= 1'b0;
            on_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            top_q        <= top_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            init_idx_q   <= init_idx_d;
            raddr_q      <= raddr_d;
            data_q       <= data_d;
            rs_q         <= rs_d;
            on_q         <= on_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic: power-on wait, the per-transfer phase sequence, and
    // the choice of the following transfer when a HOLD wait completes.
    always_comb begin
        top_d        = top_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        init_idx_d   = init_idx_q;
        raddr_d      = raddr_q;
        data_d       = data_q;
        rs_d         = rs_q;
        on_d         = 1'b1;
        frame_done_d = 1'b0;

        if (top_q == TOP_PWR_WAIT) begin
            if (cnt_q == PWR_LAST) begin
                top_d      = TOP_INIT;
                init_idx_d = 2'd0;
                data_d     = init_cmd(2'd0);
                rs_d       = 1'b0;
                phase_d    = PH_SETUP;
                cnt_d      = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            case (phase_q)
                PH_FETCH: begin
                    // raddr has been on the bus for a full cycle; sample once.
                    data_d  = map_char(din);
                    rs_d    = 1'b1;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                end
                PH_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        phase_d = PH_PULSE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        phase_d = PH_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (!hold_done) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                        case (top_q)
                            TOP_INIT: begin
                                if (init_idx_q != 2'd3) begin
                                    init_idx_d = init_idx_q + 2'd1;
                                    data_d     = init_cmd(init_idx_q + 2'd1);
                                    rs_d       = 1'b0;
                                    phase_d    = PH_SETUP;
                                end else begin
                                    top_d   = TOP_LINE1_ADDR;
                                    data_d  = CMD_LINE1;
                                    rs_d    = 1'b0;
                                    phase_d = PH_SETUP;
                                end
                            end
                            TOP_LINE1_ADDR: begin
                                top_d   = TOP_LINE1_CHARS;
                                raddr_d = 5'h00;
                                phase_d = PH_FETCH;
                            end
                            TOP_LINE1_CHARS: begin
                                if (raddr_q[3:0] != 4'hF) begin
                                    raddr_d = raddr_q + 5'd1;
                                    phase_d = PH_FETCH;
                                end else begin
                                    top_d   = TOP_LINE2_ADDR;
                                    data_d  = CMD_LINE2;
                                    rs_d    = 1'b0;
                                    phase_d = PH_SETUP;
                                end
                            end
                            TOP_LINE2_ADDR: begin
                                top_d   = TOP_LINE2_CHARS;
                                raddr_d = 5'h10;
                                phase_d = PH_FETCH;
                            end
                            TOP_LINE2_CHARS: begin
                                if (raddr_q != 5'h1F) begin
                                    raddr_d = raddr_q + 5'd1;
                                    phase_d = PH_FETCH;
                                end else begin
                                    // Frame complete: wrap to line 1, never back to init.
                                    top_d        = TOP_LINE1_ADDR;
                                    data_d       = CMD_LINE1;
                                    rs_d         = 1'b0;
                                    phase_d      = PH_SETUP;
                                    frame_done_d = 1'b1;
                                end
                            end
                            default: begin
                                top_d   = TOP_PWR_WAIT;
                                phase_d = PH_SETUP;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // Outputs: everything comes from flops except en, which is decoded from
    // the phase so that reset removes it without waiting for a clock.
    always_comb begin
        raddr      = raddr_q;
        lcd_data   = data_q;
        lcd_rs     = rs_q;
        lcd_rw     = 1'b0;
        lcd_en     = (top_q != TOP_PWR_WAIT) && (phase_q == PH_PULSE);
        lcd_on     = on_q;
        frame_done = frame_done_q;
    end

endmodule

// File: tb/tb_lcd_refresh_driver.sv
// tb_lcd_refresh_driver
// Directed bench with short timing parameters. A negedge monitor records
// every en pulse (rs/data at the rise, rise cycle, width, setup stability,
// any bus change while en is high) plus frame_done pulses; the main thread
// drives the buffer model and compares the records to hand-written values.

module tb_lcd_refresh_driver;

    logic       clk;
    logic       rst;
    logic [4:0] raddr;
    logic [7:0] din;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;
    logic       frame_done;

    logic [7:0] mem     [0:31];
    logic [7:0] exp_out [0:31];

    assign din = mem[raddr];

    lcd_refresh_driver #(
        .PWR_WAIT_CYC (20),
        .SETUP_CYC    (2),
        .EN_PULSE_CYC (4),
        .CMD_WAIT_CYC (10),
        .CLR_WAIT_CYC (50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raddr      (raddr),
        .din        (din),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_on     (lcd_on),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- monitor ----------------
    int         cyc;
    int         n;
    int         rel_cyc;
    int         stable;
    int         hcnt;
    logic       chg;
    logic       en_prev;
    logic [8:0] prev_bus;
    int         fd_cnt;
    int         fd_wide;
    logic       fd_prev;
    logic [8:0] xq_bus    [0:255];
    int         xq_rise   [0:255];
    int         xq_width  [0:255];
    int         xq_stable [0:255];
    logic       xq_chg    [0:255];

    wire [8:0] bus = {lcd_rs, lcd_data};

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            n        <= 0;
            rel_cyc  <= cyc;
            stable   <= 0;
            hcnt     <= 0;
            chg      <= 1'b0;
            en_prev  <= 1'b0;
            prev_bus <= bus;
            fd_cnt   <= 0;
            fd_wide  <= 0;
            fd_prev  <= 1'b0;
        end else begin
            stable   <= (bus == prev_bus) ? stable + 1 : 0;
            prev_bus <= bus;
            en_prev  <= lcd_en;
            if (lcd_en && !en_prev) begin
                if (n < 256) begin
                    xq_bus[n]    <= bus;
                    xq_rise[n]   <= cyc;
                    xq_stable[n] <= (bus == prev_bus) ? stable + 1 : 0;
                    n            <= n + 1;
                end
                hcnt <= 1;
                chg  <= 1'b0;
            end else if (lcd_en) begin
                hcnt <= hcnt + 1;
                if (bus != prev_bus) chg <= 1'b1;
            end else if (en_prev && n > 0) begin
                xq_width[n-1] <= hcnt;
                xq_chg[n-1]   <= chg;
            end
            if (frame_done) begin
                if (!fd_prev) fd_cnt  <= fd_cnt + 1;
                else          fd_wide <= fd_wide + 1;
            end
            fd_prev <= frame_done;
        end
    end

    // ---------------- checking ----------------
    int checks;
    int errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_xfers(input int k, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (n >= k) break;
        end
        check_eq($sformatf("reach_xfer_%0d", k), (n >= k) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Transfer index of the character at buffer address a in frame f.
    function automatic int idx(input int f, input int a);
        return 4 + 34 * f + 1 + a + ((a >= 16) ? 1 : 0);
    endfunction

    // Expected display byte; raddr 0x16 is rewritten during frame 1.
    function automatic logic [7:0] exp_byte(input int f, input int a);
        if (f >= 2 && a == 22) return 8'h37;
        return exp_out[a];
    endfunction

    function automatic logic [8:0] exp_bus(input int i);
        int f;
        int j;
        case (i)
            0: return {1'b0, 8'h38};
            1: return {1'b0, 8'h0C};
            2: return {1'b0, 8'h06};
            3: return {1'b0, 8'h01};
            default: ;
        endcase
        f = (i - 4) / 34;
        j = (i - 4) % 34;
        if (j == 0)  return {1'b0, 8'h80};
        if (j == 17) return {1'b0, 8'hC0};
        if (j < 17)  return {1'b1, exp_byte(f, j - 1)};
        return {1'b1, exp_byte(f, j - 2)};
    endfunction

    task automatic reset_checks();
        check_eq("rst_raddr",  {27'd0, raddr},    32'h0);
        check_eq("rst_data",   {24'd0, lcd_data}, 32'h0);
        check_eq("rst_rs",     {31'd0, lcd_rs},   32'h0);
        check_eq("rst_rw",     {31'd0, lcd_rw},   32'h0);
        check_eq("rst_en",     {31'd0, lcd_en},   32'h0);
        check_eq("rst_on",     {31'd0, lcd_on},   32'h0);
        check_eq("rst_fdone",  {31'd0, frame_done}, 32'h0);
    endtask

    task automatic init_seq_checks(input string pfx);
        check_eq({pfx, "_first_rise"}, xq_rise[0] - rel_cyc, 32'd22);
        check_eq({pfx, "_cmd0"}, {23'd0, xq_bus[0]}, {23'd0, 1'b0, 8'h38});
        check_eq({pfx, "_cmd1"}, {23'd0, xq_bus[1]}, {23'd0, 1'b0, 8'h0C});
        check_eq({pfx, "_cmd2"}, {23'd0, xq_bus[2]}, {23'd0, 1'b0, 8'h06});
        check_eq({pfx, "_cmd3"}, {23'd0, xq_bus[3]}, {23'd0, 1'b0, 8'h01});
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("%s_width%0d", pfx, i), xq_width[i], 32'd4);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;

        // Buffer: "TIME:" line with mapping corner cases, "3 MIN 42" line.
        mem[0]  = 8'h54; mem[1]  = 8'h49; mem[2]  = 8'h4D; mem[3]  = 8'h45;
        mem[4]  = 8'h3A; mem[5]  = 8'h0A; mem[6]  = 8'h7E; mem[7]  = 8'h20;
        mem[8]  = 8'h00; mem[9]  = 8'h09; mem[10] = 8'h1F; mem[11] = 8'h7F;
        mem[12] = 8'h41; mem[13] = 8'h20; mem[14] = 8'h80; mem[15] = 8'h7D;
        mem[16] = 8'h03; mem[17] = 8'h20; mem[18] = 8'h4D; mem[19] = 8'h49;
        mem[20] = 8'h4E; mem[21] = 8'h20; mem[22] = 8'h04; mem[23] = 8'h02;
        for (int a = 24; a < 31; a++) mem[a] = 8'h20;
        mem[31] = 8'h21;

        exp_out[0]  = 8'h54; exp_out[1]  = 8'h49; exp_out[2]  = 8'h4D; exp_out[3]  = 8'h45;
        exp_out[4]  = 8'h3A; exp_out[5]  = 8'h20; exp_out[6]  = 8'h7E; exp_out[7]  = 8'h20;
        exp_out[8]  = 8'h30; exp_out[9]  = 8'h39; exp_out[10] = 8'h20; exp_out[11] = 8'h20;
        exp_out[12] = 8'h41; exp_out[13] = 8'h20; exp_out[14] = 8'h20; exp_out[15] = 8'h7D;
        exp_out[16] = 8'h33; exp_out[17] = 8'h20; exp_out[18] = 8'h4D; exp_out[19] = 8'h49;
        exp_out[20] = 8'h4E; exp_out[21] = 8'h20; exp_out[22] = 8'h34; exp_out[23] = 8'h32;
        for (int a = 24; a < 31; a++) exp_out[a] = 8'h20;
        exp_out[31] = 8'h21;

        repeat (3) @(negedge clk);
        reset_checks();
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("on_after_rst", {31'd0, lcd_on}, 32'h1);
        check_eq("rw_low",       {31'd0, lcd_rw}, 32'h0);

        // Frame 0 has fetched raddr 5; later frames see 0xFF there.
        wait_xfers(idx(0, 5) + 1, 2000);
        mem[5] = 8'hFF;
        // Frame 1 has fetched raddr 0x16; only frame 2 may show the new value.
        wait_xfers(idx(1, 22) + 1, 3000);
        mem[22] = 8'h07;
        // Through the line-1 address command of frame 3.
        wait_xfers(4 + 34 * 3 + 1, 3000);

        init_seq_checks("init");
        check_eq("clr_gap", xq_rise[4] - xq_rise[3] - xq_width[3] - 2, 32'd50);
        check_eq("cmd_gap", xq_rise[1] - xq_rise[0] - xq_width[0] - 2, 32'd10);
        check_eq("chr_gap", xq_rise[idx(0, 1)] - xq_rise[idx(0, 0)] - xq_width[idx(0, 0)], 32'd13);
        check_eq("line1_cmd", {24'd0, xq_bus[4][7:0]}, 32'h80);
        check_eq("T_char",    {24'd0, xq_bus[idx(0, 0)][7:0]}, 32'h54);
        check_eq("colon",     {24'd0, xq_bus[idx(0, 4)][7:0]}, 32'h3A);
        check_eq("line2_cmd", {24'd0, xq_bus[21][7:0]}, 32'hC0);
        check_eq("map_0x0A",  {24'd0, xq_bus[idx(0, 5)][7:0]}, 32'h20);
        check_eq("map_0xFF",  {24'd0, xq_bus[idx(1, 5)][7:0]}, 32'h20);
        check_eq("map_0x7E",  {24'd0, xq_bus[idx(0, 6)][7:0]}, 32'h7E);
        check_eq("digit_3",   {24'd0, xq_bus[idx(0, 16)][7:0]}, 32'h33);
        check_eq("digit_4",   {24'd0, xq_bus[idx(0, 22)][7:0]}, 32'h34);
        check_eq("digit_2",   {24'd0, xq_bus[idx(0, 23)][7:0]}, 32'h32);
        check_eq("late_old",  {24'd0, xq_bus[idx(1, 22)][7:0]}, 32'h34);
        check_eq("late_new",  {24'd0, xq_bus[idx(2, 22)][7:0]}, 32'h37);
        check_eq("frames",    fd_cnt,  32'd3);
        check_eq("fd_width",  fd_wide, 32'd0);

        for (int i = 0; i < 4 + 34 * 3; i++) begin
            $display("xfer %0d rs=%0d data=0x%02h width=%0d setup=%0d",
                     i, xq_bus[i][8], xq_bus[i][7:0], xq_width[i], xq_stable[i]);
            check_eq($sformatf("bus[%0d]", i),    {23'd0, xq_bus[i]}, {23'd0, exp_bus(i)});
            check_eq($sformatf("width[%0d]", i),  xq_width[i], 32'd4);
            check_eq($sformatf("setup[%0d]", i),  (xq_stable[i] >= 2) ? 32'd1 : 32'd0, 32'd1);
            check_eq($sformatf("hold[%0d]", i),   {31'd0, xq_chg[i]}, 32'h0);
        end

        // Reset in the middle of a character pulse.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (lcd_en && lcd_rs) break;
        end
        check_eq("mid_char", {31'd0, lcd_en & lcd_rs}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check_eq("async_en", {31'd0, lcd_en}, 32'h0);
        check_eq("async_on", {31'd0, lcd_on}, 32'h0);
        repeat (2) @(negedge clk);
        reset_checks();
        @(negedge clk);
        #1 rst = 1'b0;
        wait_xfers(4, 500);
        init_seq_checks("reinit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
